// File: rtl/seq_detect_ctrl.sv
// Word-to-serial sequencer around an overlapping Moore pattern detector.
// Accepts a word, shifts it MSB-first through the detector and reports the match count.
module seq_detect_ctrl #(
    parameter int                 WORD_W  = 8,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              keep_hist,
    output logic              bit_out,
    output logic              hit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last_hit
);

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PAT_LEN-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                last_hit_q, last_hit_d;
    logic                hit_q, hit_d;
    logic                bit_out_q, bit_out_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [PAT_LEN-1:0]  hist_nxt;
    logic [FILL_W-1:0]   fill_nxt;
    logic                match;

    // Detector view of the bit currently presented on bit_out
    always_comb begin
        hist_nxt = {hist_q[PAT_LEN-2:0], bit_out_q};
        if (fill_q == FILL_W'(PAT_LEN)) begin
            fill_nxt = fill_q;
        end else begin
            fill_nxt = fill_q + FILL_W'(1);
        end
        match = (hist_nxt == PATTERN) && (fill_nxt == FILL_W'(PAT_LEN));
    end

    // Next-state and next-output logic of the sequencing FSM
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        count_d     = count_q;
        last_hit_d  = last_hit_q;
        hit_d       = 1'b0;
        bit_out_d   = 1'b0;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = SHIFT;
                    bit_out_d  = in_data[WORD_W-1];
                    shreg_d    = {in_data[WORD_W-2:0], 1'b0};
                    idx_d      = '0;
                    count_d    = '0;
                    last_hit_d = 1'b0;
                    in_ready_d = 1'b0;
                    if (!keep_hist) begin
                        hist_d = '0;
                        fill_d = '0;
                    end else begin
                        hist_d = hist_q;
                        fill_d = fill_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                hist_d     = hist_nxt;
                fill_d     = fill_nxt;
                hit_d      = match;
                last_hit_d = match;
                if (match) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    count_d = count_q;
                end
                // The final bit's match lands in the same edge that enters REPORT
                if (idx_q == IDX_W'(WORD_W - 1)) begin
                    state_d     = REPORT;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    bit_out_d = shreg_q[WORD_W-1];
                    shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            last_hit_q  <= 1'b0;
            hit_q       <= 1'b0;
            bit_out_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            last_hit_q  <= last_hit_d;
            hit_q       <= hit_d;
            bit_out_q   <= bit_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_count    = count_q;
    assign out_last_hit = last_hit_q;
    assign hit          = hit_q;
    assign bit_out      = bit_out_q;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Controller that sequences a serial pattern detector from a parallel word stream. It accepts a WORD_W-bit word over a valid/ready handshake and shifts it MSB-first, one bit per clock, through an internal Moore-style overlapping pattern detector. It counts the matches in that word and returns the count over a second valid/ready handshake. It sits between a word-oriented producer and the serial Mealy/Moore detector datapath, replacing hand-driven bit stimulus.

## Interface
- WORD_W, 8, bits per input word.
- PAT_LEN, 4, pattern length in bits; 2 ≤ PAT_LEN ≤ WORD_W.
- PATTERN, 4'b1101, PAT_LEN-bit pattern; the leftmost bit is the earliest bit received.
- CNT_W, 4, count width; must satisfy 2^CNT_W > WORD_W.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  high only in IDLE.
- in_data  in  WORD_W  word to scan.
- keep_hist  in  1  sampled on accept; 1 = detector history carries over from the previous word, 0 = history cleared.
- bit_out  out  1  serial bit being presented this cycle; 0 outside SHIFT.
- hit  out  1  registered Moore output; high the cycle after a bit completes PATTERN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_count  out  CNT_W  matches found in the accepted word.
- out_last_hit  out  1  final bit of the word completed a match.

## Operation
- The state machine has three states: IDLE, SHIFT and REPORT.
  - IDLE: in_ready=1. On in_valid && in_ready, latch in_data into the shift register, clear the count and bit index, and apply keep_hist. Go to SHIFT.
  - SHIFT: each cycle, bit_out = shreg[WORD_W-1], then shift left. After WORD_W bits, go to REPORT.
  - REPORT: out_valid=1. out_count and out_last_hit are held stable. On out_ready, go to IDLE.
- Detector:
  - The history register hist[PAT_LEN-1:0] is updated to {hist[PAT_LEN-2:0], bit_out} on each SHIFT cycle.
  - fill counts valid history bits and saturates at PAT_LEN.
  - A match occurs when the updated hist equals PATTERN and the updated fill equals PAT_LEN.
  - Matches overlap, so 1101101 yields two hits.
  - On a match, count is incremented and hit is registered on the same edge.
- keep_hist=0 on accept: hist and fill are cleared. keep_hist=1: hist and fill are preserved, so a match spanning a word boundary is counted in the new word.
- in_valid is ignored outside IDLE. out_ready is ignored outside REPORT.
- The count cannot overflow, because the number of matches is at most WORD_W.

## Timing
- Accept edge at cycle T. Bits are presented on bit_out in cycles T+1 through T+WORD_W, bit i = in_data[WORD_W-1-i].
- hit for the bit presented in cycle k is high in cycle k+1, for exactly one cycle per match.
- out_valid rises in cycle T+WORD_W+1. The final bit's match is already included in out_count and out_last_hit.
- A handshake in cycle R returns to IDLE at R+1, with in_ready=1. Minimum period is WORD_W+2 cycles per word.
- Reset values, one edge after rst=0: state IDLE, in_ready=1, out_valid=0, out_count=0, out_last_hit=0, hit=0, bit_out=0, hist=0, fill=0.
- rst=0 mid-SHIFT or mid-REPORT aborts the word. No result is emitted. Retained history is discarded.
- in_valid asserted while rst=0 is not accepted.

## Test plan
- PATTERN=1101, keep_hist=0, in_data=8'b1101_1010 -> bit_out sequence 1,1,0,1,1,0,1,0; hit high at T+5 and T+8; out_valid at T+9; out_count=2; out_last_hit=0.
- in_data=8'b1101_1101, keep_hist=0 -> out_count=2, out_last_hit=1; hit high at T+5 and T+9.
- Word 8'b0000_0110 (count 0), then 8'b1000_0000 with keep_hist=1 -> second word out_count=1, hit at T+2. Repeat with keep_hist=0 -> out_count=0.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT while in_valid=1 -> out_valid stays 1, out_count stays stable, in_ready stays 0, no new word is accepted. Release out_ready -> in_ready=1 on the next cycle.
- Assert rst=0 for one cycle during the 3rd SHIFT bit -> next cycle shows IDLE, in_ready=1, out_valid=0, hist cleared. A following word 8'b1101_0000 with keep_hist=1 gives out_count=1.
- Back-to-back: in_valid held high with out_ready=1 for 3 words -> accepts spaced exactly WORD_W+2 cycles apart, counts correct for each word.
